// File: rtl/uart_receiver.sv
// uart_receiver: oversampling 8N1 UART receiver with a Valid/Ack byte handshake and framing/overrun flags.
// Define UART_RX_PARITY_EN to add an even-parity bit and the ParityErr output.
module uart_receiver #(
  parameter int N = 5,
  parameter logic [N-1:0] Full = 5'd29,
  parameter logic [N-1:0] Half = 5'd14
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Rx,
  input  logic       Ack,
  output logic [7:0] Data,
  output logic       Valid,
  output logic       Busy,
  output logic       FrameErr,
`ifdef UART_RX_PARITY_EN
  output logic       ParityErr,
`endif
  output logic       Overrun
);
  typedef enum logic [2:0] {IDLE, START_CHK, DATA_BITS, PARITY_BIT, STOP_BIT, WAIT_HIGH} state_t;
  state_t state, state_n;
  logic s1, rs, rs_d, tick;
  logic [N-1:0] count, count_n;
  logic [2:0] bits, bits_n;
  logic [7:0] sr, sr_n, data_n;
  logic valid_n, ferr_n, ovr_n;
`ifdef UART_RX_PARITY_EN
  logic par, par_n, perr_n;
`endif
  assign Busy = state != IDLE;
  assign tick = count == '0;
  always_comb begin
    state_n = state;
    count_n = tick ? count : count - N'(1);
    bits_n = bits;
    sr_n = sr;
    data_n = Data;
    valid_n = Valid & ~Ack;
    ferr_n = 1'b0;
    ovr_n = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_n = par;
    perr_n = 1'b0;
`endif
    case (state)
      IDLE: if (rs_d && !rs) begin
        state_n = START_CHK;
        count_n = Half;
      end
      START_CHK: if (tick) begin
        state_n = rs ? IDLE : DATA_BITS;
        count_n = Full;
        bits_n = 3'd7;
      end
      DATA_BITS: if (tick) begin
        sr_n = {rs, sr[7:1]};
        count_n = Full;
        bits_n = bits - 3'd1;
`ifdef UART_RX_PARITY_EN
        if (bits == '0) state_n = PARITY_BIT;
`else
        if (bits == '0) state_n = STOP_BIT;
`endif
      end
`ifdef UART_RX_PARITY_EN
      PARITY_BIT: if (tick) begin
        par_n = rs;
        count_n = Full;
        state_n = STOP_BIT;
      end
`endif
      STOP_BIT: if (tick) begin
        state_n = rs ? IDLE : WAIT_HIGH;
        ferr_n = !rs;
        if (rs) begin
          data_n = sr;
          valid_n = 1'b1;
          ovr_n = Valid & ~Ack;
`ifdef UART_RX_PARITY_EN
          perr_n = ^{sr, par};
`endif
        end
      end
      // a held-low line (break) reports one framing error, then waits here
      WAIT_HIGH: if (rs) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      {s1, rs, rs_d} <= 3'b111;
      state <= IDLE;
      count <= '0;
      bits <= '0;
      sr <= '0;
      Data <= '0;
      Valid <= 1'b0;
      FrameErr <= 1'b0;
      Overrun <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par <= 1'b0;
      ParityErr <= 1'b0;
`endif
    end else begin
      {s1, rs, rs_d} <= {Rx, s1, rs};
      state <= state_n;
      count <= count_n;
      bits <= bits_n;
      sr <= sr_n;
      Data <= data_n;
      Valid <= valid_n;
      FrameErr <= ferr_n;
      Overrun <= ovr_n;
`ifdef UART_RX_PARITY_EN
      par <= par_n;
      ParityErr <= perr_n;
`endif
    end
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: table, directed and randomized checks of uart_receiver against a frame-level model.
`timescale 1ns/1ps
module tb_uart_receiver;
  localparam int P = 30;
  localparam int HALF = 14;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 10;
`else
  localparam int NB = 9;
`endif
  // Rx change to stop-sample cycle: two sync stages, half period to start mid, NB full periods
  localparam int LAT = 2 + HALF + 1 + NB * P;
  logic Clk = 0, Reset = 0, Rx = 1, Ack = 0;
  logic [7:0] Data;
  logic Valid, Busy, FrameErr, Overrun;
  int cyc = 0, checks = 0, failures = 0, done_cyc = 0;
  int ferr_cnt = 0, ovr_cnt = 0, busy_cnt = 0, perr_cnt = 0;
  int valid_rise = -1, ovr_cyc = -1, perr_cyc = -1;
  int f0, o0, b0, p0, oexp;
  logic valid_q = 0, vm, ackd;
  logic [7:0] dm, b;
  typedef struct {
    logic [7:0] b;
    logic stop;
    logic [7:0] exp_data;
    logic exp_valid;
    int exp_ferr;
  } vec_t;
  vec_t tbl[5];
`ifdef UART_RX_PARITY_EN
  logic ParityErr;
  always @(negedge Clk) if (ParityErr) begin perr_cnt++; perr_cyc = cyc; end
`endif
  uart_receiver dut (
    .Clk(Clk), .Reset(Reset), .Rx(Rx), .Ack(Ack), .Data(Data), .Valid(Valid), .Busy(Busy),
    .FrameErr(FrameErr),
`ifdef UART_RX_PARITY_EN
    .ParityErr(ParityErr),
`endif
    .Overrun(Overrun));
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;
  always @(negedge Clk) begin
    if (FrameErr) ferr_cnt++;
    if (Overrun) begin ovr_cnt++; ovr_cyc = cyc; end
    if (Busy) busy_cnt++;
    if (Valid && !valid_q) valid_rise = cyc;
    valid_q = Valid;
  end
  task automatic tick(input int n = 1);
    repeat (n) @(posedge Clk);
    #1;
  endtask
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic pulse_ack();
    Ack = 1;
    tick(1);
    Ack = 0;
  endtask
  task automatic send_frame(input logic [7:0] v, input logic stop, input logic par_ok, input logic ack_done);
    logic [10:0] f;
    int k;
    k = cyc;
    done_cyc = k + LAT;
    f = (NB == 10) ? {stop, (^v) ^ !par_ok, v, 1'b0} : {1'b1, stop, v, 1'b0};
    for (int i = 0; i < NB; i++) begin
      Rx = f[i];
      tick(P);
    end
    Rx = f[NB];
    tick(done_cyc - cyc);
    Ack = ack_done;
    tick(1);
    Ack = 0;
    tick(k + (NB + 1) * P - cyc);
    Rx = 1;
  endtask
  initial begin
    tbl[0] = '{8'hA5, 1'b1, 8'hA5, 1'b1, 0};
    tbl[1] = '{8'h00, 1'b1, 8'h00, 1'b1, 0};
    tbl[2] = '{8'hFF, 1'b1, 8'hFF, 1'b1, 0};
    tbl[3] = '{8'h3C, 1'b0, 8'hFF, 1'b0, 1};
    tbl[4] = '{8'h81, 1'b1, 8'h81, 1'b1, 0};
    #1 Reset = 1;
    tick(3);
    check("reset_outs", {Data, Valid, Busy, FrameErr, Overrun}, 0);
    Reset = 0;
    tick(5);
    check("idle_outs", {Data, Valid, Busy, FrameErr, Overrun}, 0);
    foreach (tbl[i]) begin
      pulse_ack();
      f0 = ferr_cnt;
      o0 = ovr_cnt;
      valid_rise = -1;
      send_frame(tbl[i].b, tbl[i].stop, 1'b1, 1'b0);
      if (!tbl[i].stop) begin
        tick(2 * P);
        Rx = 1;
      end
      tick(5);
      check("tbl_data", Data, tbl[i].exp_data);
      check("tbl_valid", Valid, tbl[i].exp_valid);
      check("tbl_ferr", ferr_cnt - f0, tbl[i].exp_ferr);
      check("tbl_ovr", ovr_cnt - o0, 0);
      if (tbl[i].exp_valid) check("tbl_valid_latency", valid_rise, done_cyc + 1);
    end
    pulse_ack();
    check("ack_clears", Valid, 0);
    send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
    tick(40);
    check("hold_valid", Valid, 1);
    check("hold_data", Data, 8'hA5);
    Ack = 1;
    check("valid_before_edge", Valid, 1);
    tick(1);
    Ack = 0;
    check("valid_falls", Valid, 0);
    pulse_ack();
    tick(2);
    check("ack_ignored", {Valid, Data}, {1'b0, 8'hA5});
    b0 = busy_cnt;
    f0 = ferr_cnt;
    Rx = 0;
    tick(10);
    Rx = 1;
    tick(40);
    check("false_start_busy", busy_cnt - b0, HALF + 1);
    check("false_start_valid", Valid, 0);
    check("false_start_ferr", ferr_cnt - f0, 0);
    check("false_start_idle", Busy, 0);
    o0 = ovr_cnt;
    send_frame(8'h3C, 1'b1, 1'b1, 1'b0);
    send_frame(8'hC3, 1'b1, 1'b1, 1'b0);
    tick(5);
    check("b2b_ovr", ovr_cnt - o0, 1);
    check("b2b_ovr_cycle", ovr_cyc, done_cyc + 1);
    check("b2b_data", {Valid, Data}, {1'b1, 8'hC3});
    pulse_ack();
    o0 = ovr_cnt;
    send_frame(8'h3C, 1'b1, 1'b1, 1'b0);
    send_frame(8'hC3, 1'b1, 1'b1, 1'b1);
    tick(5);
    check("ack_done_no_ovr", ovr_cnt - o0, 0);
    check("ack_done_data", {Valid, Data}, {1'b1, 8'hC3});
    Rx = 0;
    tick(P);
    Rx = 1;
    tick(3 * P + P / 2);
    Reset = 1;
    #1;
    check("reset_mid_frame", {Data, Valid, Busy, FrameErr, Overrun}, 0);
    tick(2);
    Reset = 0;
    tick(300);
    check("reset_no_valid", Valid, 0);
    send_frame(8'h55, 1'b1, 1'b1, 1'b0);
    tick(5);
    check("after_reset_data", {Valid, Data}, {1'b1, 8'h55});
`ifdef UART_RX_PARITY_EN
    pulse_ack();
    p0 = perr_cnt;
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    tick(5);
    check("par_good", {Valid, Data}, {1'b1, 8'h07});
    check("par_good_err", perr_cnt - p0, 0);
    pulse_ack();
    send_frame(8'h07, 1'b1, 1'b0, 1'b0);
    tick(5);
    check("par_bad", {Valid, Data}, {1'b1, 8'h07});
    check("par_bad_err", perr_cnt - p0, 1);
    check("par_err_with_valid", perr_cyc, valid_rise);
`endif
    pulse_ack();
    check("rand_start", Valid, 0);
    vm = 0;
    oexp = 0;
    o0 = ovr_cnt;
    for (int i = 0; i < 20; i++) begin
      b = 8'($urandom);
      ackd = $urandom_range(0, 3) == 0;
      send_frame(b, 1'b1, 1'b1, ackd);
      if (vm && !ackd) oexp++;
      vm = 1;
      dm = b;
      check("rand_data", Data, dm);
      check("rand_valid", Valid, vm);
      check("rand_ovr", ovr_cnt - o0, oexp);
      case ($urandom_range(0, 2))
        1: begin pulse_ack(); vm = 0; end
        2: begin pulse_ack(); pulse_ack(); vm = 0; end
        default: ;
      endcase
      tick($urandom_range(0, 40));
      check("rand_valid_gap", Valid, vm);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- UART 8N1 receiver; the receive-side counterpart of the team's UART transmitter on the same board link.
- Oversamples the asynchronous Rx line with the system clock and recovers bytes LSB-first.
- Presents each byte on a Valid/Ack handshake to downstream logic.
- Flags framing and overrun errors; optional even-parity checking.

Parameters:
- N, 5, width of the bit-timing counter.
- Full, 5'd29, Clk/BAUD - 1; one bit period is Full+1 cycles.
- Half, 5'd14, (Full+1)/2 - 1; delay from the start edge to the start-bit mid-sample.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Rx  input  1  serial line from board pin; asynchronous, idle high.
- Data  output  8  last received byte; stable while Valid=1.
- Valid  output  1  byte available; held until accepted by Ack.
- Ack  input  1  consumer accepts byte; sampled only while Valid=1.
- Busy  output  1  high from start-edge detection until return to Idle.
- FrameErr  output  1  one-cycle pulse: stop bit sampled low.
- Overrun  output  1  one-cycle pulse: new byte completed while Valid=1 and Ack=0.

Behaviour:
- Reset (async): Data=0, Valid=0, Busy=0, FrameErr=0, Overrun=0, ParityErr=0 (if built), Count=0, State=Idle, both Rx sync flops=1.
- Rx passes through a 2-flop synchronizer (rs); edge detection uses rs and its previous value.
- Counter Count (N bits): loaded with Half or Full, decrements each cycle, and the state acts only when Count==0. Same scheme as the transmitter.
- States: Idle, StartChk, DataBits, (ParityBit), StopBit, WaitHigh.
- Idle: Busy=0. A falling edge on rs at cycle t0 loads Count=Half, sets Busy=1 and goes to StartChk.
- StartChk: start sample at t0+Half+1.
  - rs=1: false start; return to Idle, Busy=0, no outputs.
  - rs=0: load Full and BitCount=7; go to DataBits.
- DataBits: each sample shifts rs into a shift register MSB-in, so the byte is LSB-first. Data bit k is sampled at t0+Half+1+(k+1)(Full+1). Reload Full after each sample. After BitCount==0, go to StopBit (or ParityBit if built).
- StopBit, sampled one period after the last data/parity bit:
  - rs=1: Data <= shift register, Valid <= 1 on the next cycle, go to Idle with Busy=0.
  - rs=0: FrameErr pulses, Data and Valid unchanged, go to WaitHigh.
- WaitHigh: stay until rs=1, then Idle. A line held low (break) produces exactly one FrameErr.
- Handshake:
  - Valid falls the cycle after Valid=1 and Ack=1.
  - Ack while Valid=0 is ignored.
- Byte completing while Valid=1 and Ack=0: Data is overwritten, Valid stays 1, Overrun pulses.
- Byte completing in the same cycle Ack=1: Valid stays 1 with the new Data, no Overrun.
- Back-to-back frames: a start edge arriving right after the stop sample is accepted; there is no dead time beyond the return to Idle.
- Reset mid-frame aborts immediately. The partial byte is discarded and the next falling edge starts a fresh frame.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined:
  - Adds ParityBit state and output port ParityErr (1 bit, reset 0).
  - Parity is sampled one period after data bit 7; the stop bit follows one period later.
  - Even parity required: XOR of the 8 data bits and the parity bit = 0.
  - Mismatch with a good stop bit: ParityErr pulses together with Valid; Data is still delivered.
- Undefined: 8N1 only; no ParityErr port; the stop bit follows data bit 7.

Test Plan (Full=29, Half=14, bit period 30 cycles):
- Send 0xA5 framed 8N1, Ack held 0 -> Data=0xA5, Valid=1 one cycle after the stop sample and held. Ack=1 for one cycle -> Valid=0 next cycle.
- Rx low pulse of 10 cycles, then high -> no Valid, no FrameErr; Busy high about 15 cycles, then 0.
- Send 0x3C with the stop bit driven low, then Rx high after 90 cycles -> single FrameErr pulse, Valid stays 0. Then send 0x81 -> Data=0x81, Valid=1.
- Send 0x3C then 0xC3 back-to-back, no Ack -> Overrun pulse at the second stop sample, Data=0xC3, Valid=1. Repeat with Ack asserted in the completion cycle -> no Overrun.
- Assert Reset during data bit 3 of 0xFF -> all outputs 0 immediately, no Valid. Then send 0x55 cleanly -> Data=0x55, Valid=1.
- UART_RX_PARITY_EN: send 0x07 with parity 1 -> Valid, ParityErr=0. Send 0x07 with parity 0 -> Valid plus ParityErr pulse, Data=0x07.
